// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift a byte
// with odd parity on device clock edges, check ACK, hand the bus back.
module ps2_host_tx_ctrl #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 2000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       Bus2IP_Clk,
    input  logic       Bus2IP_Resetn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_enable,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;
    logic timed_out;

    // Synchronizers idle high so reset never fakes a falling edge.
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_data_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall      = clk_prev_q & ~clk_sync_q;
    assign timed_out = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d   = S_INHIBIT;
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    state_d   = S_RTS;
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                end
            end
            S_RTS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RTS_CYCLES - 1)) begin
                    // Data stays low as the start bit; timeout runs from here.
                    state_d  = S_SHIFT;
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                end
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                cnt_d = cnt_q + CW'(1);
                if (timed_out) begin
                    state_d   = S_IDLE;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                end else if (state_q == S_SHIFT) begin
                    if (fall) begin
                        data_oe_d = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    if (fall) begin
                        if (!dat_sync_q) begin
                            state_d = S_WAIT_IDLE;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end else begin
                    if (clk_sync_q && dat_sync_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            frame_q   <= '1;
            bit_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign rx_enable   = (state_q == S_IDLE);
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Bench for ps2_host_tx_ctrl: open-drain device model on pulled-up lines
// and a frame/timing reference derived from the PS/2 host-send rules.
`timescale 1ns/1ps
module tb_ps2_host_tx_ctrl;

    localparam int INH  = 20;
    localparam int RTS  = 5;
    localparam int TMO  = 3000;
    localparam int HALF = 5000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, tx_done, tx_err, rx_enable;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    int checks = 0;
    int errors = 0;

    always #25 clk = ~clk;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx_ctrl #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES(RTS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Bus2IP_Clk(clk),
        .Bus2IP_Resetn(rst_n),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .rx_enable(rx_enable),
        .ps2_clk_in(clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Running totals observed on every falling system-clock edge.
    int   cyc = 0, tot_clk = 0, tot_both = 0, tot_done = 0, tot_err = 0;
    int   tot_bad = 0, rel_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ps2_clk_oe === 1'b1) tot_clk++;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) tot_both++;
        if (ps2_clk_oe === 1'b0 && prev_clk_oe === 1'b1) rel_cyc = cyc;
        prev_clk_oe = ps2_clk_oe;
        if (tx_done === 1'b1) tot_done++;
        if (tx_err === 1'b1) begin
            tot_err++;
            err_cyc = cyc;
        end
        if ((tx_done === 1'b1 && tx_err === 1'b1) ||
            ((tx_done === 1'b1 || tx_err === 1'b1) && tx_ready !== 1'b1))
            tot_bad++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] d);
        for (int k = 0; k < 20 && tx_ready !== 1'b1; k++) tick();
        check("ready_before_accept", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("ready_low_after_accept", {tx_ready, rx_enable, ps2_clk_oe}, 3'b001);
    endtask

    task automatic wait_release(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (clk_line === 1'b1 && data_line === 1'b0) ok = 1'b1;
            else tick();
        end
    endtask

    // Device: 10 us clock, samples host data while its clock is low.
    task automatic device(input int n_edges, input bit ack, output logic [9:0] bits);
        bits = '0;
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 11 && ack) begin
                #(HALF / 2);
                dev_data_low = 1'b1;
                #(HALF / 2);
            end else begin
                #(HALF);
            end
            dev_clk_low = 1'b1;
            if (i == n_edges && n_edges < 11) return;
            #(HALF);
            if (i <= 10) bits[i-1] = data_line;
            dev_clk_low = 1'b0;
        end
        #(HALF);
        dev_data_low = 1'b0;
    endtask

    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic xfer(input logic [7:0] d, input bit ack);
        int b_clk, b_both, b_done, b_err;
        logic [9:0] bits;
        bit ok;
        b_clk  = tot_clk;
        b_both = tot_both;
        b_done = tot_done;
        b_err  = tot_err;
        accept(d);
        wait_release(ok);
        check("clock_release", ok, 1);
        if (ok) device(11, ack, bits);
        else bits = '0;
        for (int k = 0; k < 4000 && (tot_done + tot_err) == (b_done + b_err); k++) tick();
        check("device_bits", bits, ref_frame(d));
        check("clk_oe_cycles", tot_clk - b_clk, INH + RTS);
        check("rts_cycles", tot_both - b_both, RTS);
        check("done_count", tot_done - b_done, ack ? 1 : 0);
        check("err_count", tot_err - b_err, ack ? 0 : 1);
        tick();
        check("idle_after", {ps2_clk_oe, ps2_data_oe, tx_ready, rx_enable}, 4'b0011);
    endtask

    initial begin
        logic [9:0] bits;
        int b_done, b_err;
        bit ok;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        check("reset_state", {ps2_clk_oe, ps2_data_oe, tx_ready, rx_enable, tx_done, tx_err},
              6'b001100);
        rst_n = 1'b1;
        tick();
        check("post_reset", {ps2_clk_oe, ps2_data_oe, tx_ready, rx_enable, tx_done, tx_err},
              6'b001100);

        xfer(8'h4B, 1'b1);
        xfer(8'h01, 1'b1);
        xfer(8'hFF, 1'b1);
        xfer(8'($urandom), 1'b0);

        // Device never clocks: timeout measured from clock release.
        b_done = tot_done;
        b_err  = tot_err;
        accept(8'hA5);
        wait_release(ok);
        check("timeout_release", ok, 1);
        for (int k = 0; k < TMO + 500 && tot_err == b_err; k++) tick();
        check("timeout_err", tot_err - b_err, 1);
        check("timeout_no_done", tot_done - b_done, 0);
        check("timeout_latency", err_cyc - rel_cyc, TMO);
        check("timeout_lines", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);

        // Reset in the middle of the shift phase.
        b_done = tot_done;
        b_err  = tot_err;
        accept(8'h4B);
        wait_release(ok);
        check("abort_release", ok, 1);
        device(4, 1'b0, bits);
        repeat (10) tick();
        check("abort_bit3", ps2_data_oe, 1'b0);
        rst_n = 1'b0;
        tick();
        check("abort_reset", {ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err}, 5'b00100);
        rst_n = 1'b1;
        dev_clk_low = 1'b0;
        repeat (20) tick();
        check("abort_no_pulse", (tot_done - b_done) + (tot_err - b_err), 0);
        xfer(8'h4B, 1'b1);

        repeat (3) xfer(8'($urandom), ($urandom % 4) != 0);

        check("pulse_rules", tot_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
